mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store unit between the pipeline's memory stage and a variable-latency data bus. It takes the M-stage address, store data, size and signedness, and does four jobs: byte-lane alignment and byte enables, a req/ack bus handshake, stall generation toward the hazard unit, and aligning plus sign/zero-extending load data. Load data is returned registered, so it is valid in the W stage.

## Interface
Parameters:
- TIMEOUT_CYCLES, 15: maximum BUSY cycles without `bus_ack` before the access is aborted (range 1..255).

Ports:
- `clk`  in  1  clock, rising-edge.
- `reset_x`  in  1  reset, asynchronous, active-low.
- `Mi_memRead`  in  1  M-stage load request.
- `Mi_memWrite`  in  1  M-stage store request; wins if both are high.
- `Mi_memSize`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `Mi_isLoadSigned`  in  1  1 = sign-extend loads, 0 = zero-extend.
- `Mi_addr`  in  32  byte address (ALU result).
- `Mi_writeData`  in  32  store data, right-justified.
- `Mo_stall`  out  1  freeze F..M stages; combinational.
- `Wo_loadData`  out  32  extended load data; registered.
- `Wo_loadValid`  out  1  one-cycle pulse qualifying `Wo_loadData`.
- `o_busError`  out  1  one-cycle pulse on timeout abort.
- `o_misalign`  out  1  one-cycle pulse on misaligned request; tied 0 when the feature is compiled out.
- `bus_req`  out  1  bus request; registered.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word address, `{Mi_addr[31:2],2'b00}`.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_ack`  in  1  access complete; `bus_rdata` is valid in the same cycle.
- `bus_rdata`  in  32  read word.

## Operation
- FSM states: IDLE and BUSY.
- IDLE with a request: latch we/addr/size/signed/wdata, go to BUSY, set `bus_req` = 1.
- BUSY: hold every `bus_*` output stable until `bus_ack`.
  - On ack: return to IDLE and drop `bus_req`.
  - On ack for a read: capture the extended data and pulse `Wo_loadValid` next cycle.
  - On ack for a write: no `Wo_loadValid` pulse.
- `Mo_stall` = (IDLE & request) | (BUSY & ~bus_ack & ~timeout).
  - The pipeline advances in the ack cycle.
  - The request seen in the following IDLE cycle therefore belongs to the next instruction.
- Byte enables:
  - Byte: `bus_be` = 1 << addr[1:0]; `bus_wdata` = the byte replicated ×4.
  - Half: `bus_be` = addr[1] ? 1100 : 0011; `bus_wdata` = the half replicated ×2.
  - Word: `bus_be` = 1111; `bus_wdata` = `Mi_writeData`.
- Load extraction: byte lane `rdata[8*addr[1:0]+:8]`, half lane `rdata[16*addr[1]+:16]`. Extend to 32 bits per the latched signedness.
- Timeout: an 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When count == TIMEOUT_CYCLES−1 with no ack: drop `bus_req`, go to IDLE and pulse `o_busError`.
  - A read that times out also pulses `Wo_loadValid` with `Wo_loadData` = 0.
  - Ack and timeout in the same cycle: ack wins, no error.
- Reset asserted mid-access: immediately go to IDLE; `bus_req` and all pulses go to 0; the in-flight access is discarded.

## Timing
- Reset values:
  - FSM = IDLE.
  - `bus_req`, `bus_we`, `Wo_loadValid`, `o_busError`, `o_misalign` = 0.
  - `bus_addr`, `bus_be`, `bus_wdata`, `Wo_loadData`, timeout counter = 0.
- Zero-wait bus (ack in the first BUSY cycle):
  - Cycle 0: IDLE, `Mo_stall` = 1.
  - Cycle 1: `bus_req` = 1, ack, `Mo_stall` = 0.
  - Cycle 2: `Wo_loadValid` = 1.
  - Net cost: 1 stall cycle per access.
- N-cycle-late ack: `Mo_stall` high for N+1 cycles; `Wo_loadValid` one cycle after ack.
- `bus_ack` is ignored in IDLE.
- Requests while BUSY are not sampled; they are held by the stall.
- `Wo_loadData` holds its value until the next load completion.

## Configuration
- `MAU_MISALIGN_TRAP_EN` defined:
  - Misaligned cases: half with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - Such a request in IDLE starts no bus transaction and does not stall.
  - `o_misalign` pulses the following cycle.
  - A misaligned load also pulses `Wo_loadValid` with data 0.
- Undefined:
  - No misalignment detection; `o_misalign` is tied 0.
  - Half ignores addr[0]; word ignores addr[1:0].
  - All requests go to the bus.

## Test plan
- Byte store `addr`=0x1003, data 0x000000A5, ack on first BUSY cycle → `bus_be` = 1000, `bus_wdata` = 0xA5A5A5A5, `bus_addr` = 0x1000, stall exactly 1 cycle, no `Wo_loadValid`.
- Signed half load `addr`=0x2002, `rdata` = 0x8001_1234, ack after 3 wait cycles → stall 4 cycles, `Wo_loadData` = 0xFFFF8001 with a one-cycle `Wo_loadValid` after ack. Same access unsigned → 0x00008001.
- No ack with TIMEOUT_CYCLES = 4 → `bus_req` high 4 cycles then 0, `o_busError` pulse, `Wo_loadData` = 0 with valid; ack arriving on the 4th cycle → normal completion, no error.
- `reset_x` low during BUSY → `bus_req` = 0 asynchronously, FSM IDLE; after release, a word load at 0x3000 with `rdata` 0xDEADBEEF returns 0xDEADBEEF.
- Word load at 0x4002: with `MAU_MISALIGN_TRAP_EN` → no `bus_req`, `o_misalign` pulse, data 0; without it → bus access at 0x4000, `bus_be` = 1111.
- Back-to-back load then store, ack immediate each → two distinct bus transactions separated by one IDLE cycle, `bus_we` 0 then 1.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the M stage and a variable-latency
// req/ack data bus. Handles byte-lane alignment, byte enables, the bus
// handshake with a timeout abort, pipeline stall generation, and alignment
// plus sign/zero extension of load data, which is registered for the W stage.
// Optional feature macro: MAU_MISALIGN_TRAP_EN traps misaligned half/word
// requests without touching the bus.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        Mi_memRead,
  input  logic        Mi_memWrite,
  input  logic [1:0]  Mi_memSize,
  input  logic        Mi_isLoadSigned,
  input  logic [31:0] Mi_addr,
  input  logic [31:0] Mi_writeData,
  output logic        Mo_stall,
  output logic [31:0] Wo_loadData,
  output logic        Wo_loadValid,
  output logic        o_busError,
  output logic        o_misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next;
  logic        r_req, r_we, r_signed, r_loadValid, r_busError;
  logic [1:0]  r_size, r_lane;
  logic [31:0] r_addr, r_wdata, r_loadData;
  logic [3:0]  r_be;
  logic [7:0]  r_cnt;

  logic        w_req, w_misalign, w_start, w_toHit;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_req = Mi_memRead | Mi_memWrite;

`ifdef MAU_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_misalign = ((Mi_memSize == 2'b01) && Mi_addr[0]) ||
                      (Mi_memSize[1] && (Mi_addr[1:0] != 2'b00));
  assign o_misalign = r_misalign;
`else
  assign w_misalign = 1'b0;
  assign o_misalign = 1'b0;
`endif

  assign w_start = (r_state == IDLE) && w_req && !w_misalign;
  // Last permitted BUSY cycle without ack; an ack in that same cycle still wins.
  assign w_toHit = (r_state == BUSY) && !bus_ack && (r_cnt == TO_LAST);

  assign Mo_stall = w_start || ((r_state == BUSY) && !bus_ack && !w_toHit);

  // Store-side lane placement and byte enables from the live M-stage request.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = Mi_writeData;
    case (Mi_memSize)
      2'b00: begin
        w_be    = 4'b0001 << Mi_addr[1:0];
        w_wdata = {4{Mi_writeData[7:0]}};
      end
      2'b01: begin
        w_be    = Mi_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{Mi_writeData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = Mi_writeData;
      end
    endcase
  end

  // Load-side lane extraction and extension using the latched access attributes.
  always_comb begin
    w_byte = bus_rdata[{r_lane, 3'b000} +: 8];
    w_half = bus_rdata[{r_lane[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{r_signed & w_half[15]}}, w_half};
      default: w_ext = bus_rdata;
    endcase
  end

  // Next-state logic for the IDLE/BUSY handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = BUSY;
      BUSY:    if (bus_ack || w_toHit) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Bus-side latches, timeout counter, and the registered W-stage results/pulses.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_size      <= '0;
      r_lane      <= '0;
      r_signed    <= 1'b0;
      r_cnt       <= '0;
      r_loadData  <= '0;
      r_loadValid <= 1'b0;
      r_busError  <= 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
      r_loadValid <= 1'b0;
      r_busError  <= 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
      r_misalign  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_req    <= 1'b1;
            r_we     <= Mi_memWrite;
            r_addr   <= {Mi_addr[31:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_size   <= Mi_memSize;
            r_lane   <= Mi_addr[1:0];
            r_signed <= Mi_isLoadSigned;
            r_cnt    <= '0;
          end
`ifdef MAU_MISALIGN_TRAP_EN
          else if (w_req && w_misalign) begin
            r_misalign <= 1'b1;
            if (!Mi_memWrite) begin
              r_loadValid <= 1'b1;
              r_loadData  <= '0;
            end
          end
`endif
        end
        BUSY: begin
          if (bus_ack) begin
            r_req <= 1'b0;
            if (!r_we) begin
              r_loadValid <= 1'b1;
              r_loadData  <= w_ext;
            end
          end else if (w_toHit) begin
            r_req      <= 1'b0;
            r_busError <= 1'b1;
            if (!r_we) begin
              r_loadValid <= 1'b1;
              r_loadData  <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_req <= 1'b0;
      endcase
    end
  end

  assign bus_req      = r_req;
  assign bus_we       = r_we;
  assign bus_addr     = r_addr;
  assign bus_be       = r_be;
  assign bus_wdata    = r_wdata;
  assign Wo_loadData  = r_loadData;
  assign Wo_loadValid = r_loadValid;
  assign o_busError   = r_busError;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_x;
  logic        Mi_memRead, Mi_memWrite, Mi_isLoadSigned;
  logic [1:0]  Mi_memSize;
  logic [31:0] Mi_addr, Mi_writeData;
  logic        Mo_stall, Wo_loadValid, o_busError, o_misalign;
  logic [31:0] Wo_loadData;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_checks = 0;
  int n_errors = 0;

  logic        s_idle_req, s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  int          s_stalls;
  int          n_req;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .reset_x        (reset_x),
    .Mi_memRead     (Mi_memRead),
    .Mi_memWrite    (Mi_memWrite),
    .Mi_memSize     (Mi_memSize),
    .Mi_isLoadSigned(Mi_isLoadSigned),
    .Mi_addr        (Mi_addr),
    .Mi_writeData   (Mi_writeData),
    .Mo_stall       (Mo_stall),
    .Wo_loadData    (Wo_loadData),
    .Wo_loadValid   (Wo_loadValid),
    .o_busError     (o_busError),
    .o_misalign     (o_misalign),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_be         (bus_be),
    .bus_wdata      (bus_wdata),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    Mi_memRead  = 1'b0;
    Mi_memWrite = 1'b0;
    bus_ack     = 1'b0;
  endtask

  // One access: request held until the ack cycle, ack after 'waits' BUSY cycles.
  task automatic run_access(input logic wr, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int waits, input logic [31:0] rd);
    s_idle_req      = bus_req;
    Mi_memRead      = !wr;
    Mi_memWrite     = wr;
    Mi_memSize      = sz;
    Mi_isLoadSigned = sg;
    Mi_addr         = a;
    Mi_writeData    = wd;
    bus_ack         = 1'b0;
    bus_rdata       = 32'h0;
    #1;
    s_stalls = Mo_stall ? 1 : 0;
    for (int i = 0; i < waits; i++) begin
      cyc();
      #1;
      if (Mo_stall) s_stalls++;
    end
    cyc();
    s_req   = bus_req;
    s_we    = bus_we;
    s_addr  = bus_addr;
    s_be    = bus_be;
    s_wdata = bus_wdata;
    bus_ack   = 1'b1;
    bus_rdata = rd;
    #1;
    if (Mo_stall) s_stalls++;
    cyc();
    idle_inputs();
    #1;
  endtask

  initial begin
    reset_x = 1'b0;
    idle_inputs();
    Mi_memSize = 2'b00; Mi_isLoadSigned = 1'b0;
    Mi_addr = 32'h0; Mi_writeData = 32'h0; bus_rdata = 32'h0;
    cyc(); cyc();
    chk("rst_req",    bus_req,      1'b0);
    chk("rst_we",     bus_we,       1'b0);
    chk("rst_addr",   bus_addr,     32'h0);
    chk("rst_be",     bus_be,       4'h0);
    chk("rst_wdata",  bus_wdata,    32'h0);
    chk("rst_ldata",  Wo_loadData,  32'h0);
    chk("rst_lvalid", Wo_loadValid, 1'b0);
    chk("rst_berr",   o_busError,   1'b0);
    chk("rst_mis",    o_misalign,   1'b0);
    chk("rst_stall",  Mo_stall,     1'b0);
    reset_x = 1'b1;
    cyc();

    // bus_ack in IDLE is ignored
    bus_ack = 1'b1;
    #1;
    chk("idleack_stall", Mo_stall, 1'b0);
    cyc();
    chk("idleack_req",    bus_req,      1'b0);
    chk("idleack_lvalid", Wo_loadValid, 1'b0);
    bus_ack = 1'b0;
    cyc();

    // byte store at 0x1003
    run_access(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0);
    chk("bst_req",    s_req,        1'b1);
    chk("bst_we",     s_we,         1'b1);
    chk("bst_addr",   s_addr,       32'h0000_1000);
    chk("bst_be",     s_be,         4'b1000);
    chk("bst_wdata",  s_wdata,      32'hA5A5_A5A5);
    chk("bst_stalls", s_stalls,     1);
    chk("bst_lvalid", Wo_loadValid, 1'b0);
    chk("bst_reqoff", bus_req,      1'b0);
    cyc();

    // signed half load at 0x2002, ack after 3 waits (4th BUSY cycle = timeout edge)
    run_access(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 3, 32'h8001_1234);
    chk("hls_stalls", s_stalls,     4);
    chk("hls_we",     s_we,         1'b0);
    chk("hls_be",     s_be,         4'b1100);
    chk("hls_addr",   s_addr,       32'h0000_2000);
    chk("hls_lvalid", Wo_loadValid, 1'b1);
    chk("hls_ldata",  Wo_loadData,  32'hFFFF_8001);
    chk("hls_berr",   o_busError,   1'b0);
    cyc();
    chk("hls_pulse1", Wo_loadValid, 1'b0);
    chk("hls_hold",   Wo_loadData,  32'hFFFF_8001);

    // same access unsigned, zero-wait
    run_access(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 0, 32'h8001_1234);
    chk("hlu_ldata",  Wo_loadData,  32'h0000_8001);
    chk("hlu_stalls", s_stalls,     1);
    cyc();

    // signed byte load from lane 1
    run_access(1'b0, 2'b00, 1'b1, 32'h0000_7001, 32'h0, 1, 32'h1234_80FF);
    chk("bls_ldata",  Wo_loadData,  32'hFFFF_FF80);
    chk("bls_stalls", s_stalls,     2);
    cyc();

    // timeout: word load, no ack
    Mi_memRead = 1'b1; Mi_memSize = 2'b10; Mi_addr = 32'h0000_6000;
    #1;
    chk("to_stall0", Mo_stall, 1'b1);
    cyc();
    n_req = 0;
    while (bus_req && n_req < 10) begin
      n_req++;
      #1;
      if (n_req == 3) chk("to_stall3", Mo_stall, 1'b1);
      if (n_req == 4) chk("to_stall4", Mo_stall, 1'b0);
      cyc();
    end
    chk("to_reqcycles", n_req,        4);
    chk("to_berr",      o_busError,   1'b1);
    chk("to_lvalid",    Wo_loadValid, 1'b1);
    chk("to_ldata",     Wo_loadData,  32'h0);
    idle_inputs();
    cyc();
    chk("to_berr1",   o_busError,   1'b0);
    chk("to_lvalid1", Wo_loadValid, 1'b0);

    // reset asserted mid-access
    Mi_memRead = 1'b1; Mi_memSize = 2'b10; Mi_addr = 32'h0000_3000;
    cyc();
    chk("rb_busy_req", bus_req, 1'b1);
    #2;
    reset_x = 1'b0;
    #1;
    chk("rb_async_req", bus_req, 1'b0);
    idle_inputs();
    cyc();
    chk("rb_lvalid", Wo_loadValid, 1'b0);
    chk("rb_addr",   bus_addr,     32'h0);
    reset_x = 1'b1;
    cyc();
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 0, 32'hDEAD_BEEF);
    chk("rb_ldata",  Wo_loadData,  32'hDEAD_BEEF);
    chk("rb_lvalid2", Wo_loadValid, 1'b1);
    cyc();

    // misaligned word load at 0x4002
`ifdef MAU_MISALIGN_TRAP_EN
    Mi_memRead = 1'b1; Mi_memSize = 2'b10; Mi_addr = 32'h0000_4002;
    #1;
    chk("mis_stall", Mo_stall, 1'b0);
    cyc();
    idle_inputs();
    chk("mis_req",    bus_req,      1'b0);
    chk("mis_pulse",  o_misalign,   1'b1);
    chk("mis_lvalid", Wo_loadValid, 1'b1);
    chk("mis_ldata",  Wo_loadData,  32'h0);
    cyc();
    chk("mis_pulse1", o_misalign,   1'b0);
`else
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0, 0, 32'h1122_3344);
    chk("mis_req",   s_req,       1'b1);
    chk("mis_addr",  s_addr,      32'h0000_4000);
    chk("mis_be",    s_be,        4'b1111);
    chk("mis_ldata", Wo_loadData, 32'h1122_3344);
    chk("mis_flag",  o_misalign,  1'b0);
`endif
    cyc();

    // back-to-back load then store
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 0, 32'hCAFE_F00D);
    chk("b2b_we0",    s_we,         1'b0);
    chk("b2b_req0",   s_req,        1'b1);
    chk("b2b_ld",     Wo_loadData,  32'hCAFE_F00D);
    run_access(1'b1, 2'b10, 1'b0, 32'h0000_5004, 32'h1357_9BDF, 0, 32'h0);
    chk("b2b_idle",   s_idle_req,   1'b0);
    chk("b2b_we1",    s_we,         1'b1);
    chk("b2b_req1",   s_req,        1'b1);
    chk("b2b_addr1",  s_addr,       32'h0000_5004);
    chk("b2b_wdata1", s_wdata,      32'h1357_9BDF);
    chk("b2b_stall1", s_stalls,     1);
    chk("b2b_lvalid", Wo_loadValid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
